// File: rtl/spi_lcd_cmd_decoder.sv
// spi_lcd_cmd_decoder
//   Interprets the ST7735R-style byte stream coming out of the SPI slave:
//   CASET / RASET window setup, RAMWR pixel streaming (big-endian RGB565)
//   and SWRESET. Emits one frame-buffer write per assembled pixel at
//   address y*DISP_W + x, walking the cursor through the active window.
//
//   Optional feature macro: SPI_CMD_MADCTL_EN
//     When defined, command 0x36 (MADCTL) is decoded; bit3 (BGR) of its
//     first parameter byte swaps the R and B fields of every written pixel.
//     When undefined, 0x36 is treated as an unknown command.
//
//   Handshake: a byte is consumed only in a cycle where i_rxdone=1; i_data
//   and i_dc are don't-care otherwise. o_pix_we and o_frame_start are
//   one-cycle strobes with no back-pressure; o_pix_addr/o_pix_data are
//   valid in the cycle o_pix_we=1.
//
//   o_dbg_state exposes the decoder FSM state for checkers.
module spi_lcd_cmd_decoder #(
  parameter int DISP_W = 320,
  parameter int DISP_H = 240,
  parameter int ADDR_W = 17
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_data,
  input  logic              i_dc,
  input  logic              i_rxdone,
  output logic              o_pix_we,
  output logic [ADDR_W-1:0] o_pix_addr,
  output logic [15:0]       o_pix_data,
  output logic              o_frame_start,
  output logic [2:0]        o_dbg_state
);

  localparam int XW = (DISP_W > 1) ? $clog2(DISP_W) : 1;
  localparam int YW = (DISP_H > 1) ? $clog2(DISP_H) : 1;
  localparam logic [XW-1:0] X_MAX = XW'(DISP_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(DISP_H - 1);
  localparam logic [15:0]   W16   = 16'(DISP_W);
  localparam logic [15:0]   H16   = 16'(DISP_H);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    S_CASET  = 3'd1,
    S_RASET  = 3'd2,
    S_PIX_HI = 3'd3,
    S_PIX_LO = 3'd4,
    S_IGNORE = 3'd5,
    S_MADCTL = 3'd6
  } state_t;

  state_t          state_q;
  logic [XW-1:0]   xs_q, xe_q, cur_x_q, cur_x_d;
  logic [YW-1:0]   ys_q, ye_q, cur_y_q, cur_y_d;
  logic [2:0]      pcnt_q;
  logic [23:0]     sh_q;        // first three parameter bytes, oldest in [23:16]
  logic [7:0]      pix_hi_q;
  logic [15:0]     win_start, win_end;
  logic            caset_ok, raset_ok;
  logic [15:0]     pix_word, pix_out;
  logic [ADDR_W-1:0] addr_calc;
`ifdef SPI_CMD_MADCTL_EN
  logic            bgr_q;
`endif

  assign o_dbg_state = state_q;

  // Window candidate from the shadow bytes plus the byte arriving now (4th).
  always_comb begin
    win_start = sh_q[23:8];
    win_end   = {sh_q[7:0], i_data};
    caset_ok  = (win_start <= win_end) && (win_end < W16);
    raset_ok  = (win_start <= win_end) && (win_end < H16);
  end

  // Pixel assembly, optional R/B swap, and write address of the cursor.
  always_comb begin
    pix_word  = {pix_hi_q, i_data};
`ifdef SPI_CMD_MADCTL_EN
    pix_out   = bgr_q ? {pix_word[4:0], pix_word[10:5], pix_word[15:11]} : pix_word;
`else
    pix_out   = pix_word;
`endif
    addr_calc = ADDR_W'(cur_y_q) * ADDR_W'(DISP_W) + ADDR_W'(cur_x_q);
  end

  // Cursor advance: raster order inside the window, wrapping to (xs, ys).
  always_comb begin
    cur_x_d = cur_x_q + XW'(1);
    cur_y_d = cur_y_q;
    if (cur_x_q == xe_q) begin
      cur_x_d = xs_q;
      cur_y_d = (cur_y_q == ye_q) ? ys_q : cur_y_q + YW'(1);
    end
  end

  // Decoder FSM with registered strobes, window and cursor.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      xs_q          <= '0;
      xe_q          <= X_MAX;
      ys_q          <= '0;
      ye_q          <= Y_MAX;
      cur_x_q       <= '0;
      cur_y_q       <= '0;
      pcnt_q        <= '0;
      sh_q          <= '0;
      pix_hi_q      <= '0;
      o_pix_we      <= 1'b0;
      o_pix_addr    <= '0;
      o_pix_data    <= '0;
      o_frame_start <= 1'b0;
`ifdef SPI_CMD_MADCTL_EN
      bgr_q         <= 1'b0;
`endif
    end else begin
      o_pix_we      <= 1'b0;
      o_frame_start <= 1'b0;
      if (i_rxdone) begin
        if (!i_dc) begin
          // A command always aborts whatever was in progress.
          pcnt_q   <= '0;
          pix_hi_q <= '0;
          case (i_data)
            8'h2A: state_q <= S_CASET;
            8'h2B: state_q <= S_RASET;
            8'h2C: begin
              state_q       <= S_PIX_HI;
              cur_x_q       <= xs_q;
              cur_y_q       <= ys_q;
              o_frame_start <= 1'b1;
            end
            8'h01: begin
              state_q <= IDLE;
              xs_q    <= '0;
              xe_q    <= X_MAX;
              ys_q    <= '0;
              ye_q    <= Y_MAX;
`ifdef SPI_CMD_MADCTL_EN
              bgr_q   <= 1'b0;
`endif
            end
`ifdef SPI_CMD_MADCTL_EN
            8'h36:   state_q <= S_MADCTL;
`endif
            default: state_q <= S_IGNORE;
          endcase
        end else begin
          case (state_q)
            S_CASET, S_RASET: begin
              if (pcnt_q < 3'd3) begin
                sh_q   <= {sh_q[15:0], i_data};
                pcnt_q <= pcnt_q + 3'd1;
              end else if (pcnt_q == 3'd3) begin
                pcnt_q <= 3'd4;  // further bytes are dropped
                if (state_q == S_CASET && caset_ok) begin
                  xs_q <= win_start[XW-1:0];
                  xe_q <= win_end[XW-1:0];
                end
                if (state_q == S_RASET && raset_ok) begin
                  ys_q <= win_start[YW-1:0];
                  ye_q <= win_end[YW-1:0];
                end
              end
            end
            S_PIX_HI: begin
              pix_hi_q <= i_data;
              state_q  <= S_PIX_LO;
            end
            S_PIX_LO: begin
              o_pix_we   <= 1'b1;
              o_pix_addr <= addr_calc;
              o_pix_data <= pix_out;
              cur_x_q    <= cur_x_d;
              cur_y_q    <= cur_y_d;
              state_q    <= S_PIX_HI;
            end
`ifdef SPI_CMD_MADCTL_EN
            S_MADCTL: begin
              if (pcnt_q == 3'd0) begin
                bgr_q  <= i_data[3];
                pcnt_q <= 3'd1;
              end
            end
`endif
            default: ;  // IDLE / S_IGNORE drop data bytes
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_lcd_cmd_decoder.sv
// tb_spi_lcd_cmd_decoder
//   Byte-level driver for spi_lcd_cmd_decoder with a window/pixel-index
//   reference model; directed command sequences followed by random traffic.
module tb_spi_lcd_cmd_decoder;

  localparam int DISP_W = 320;
  localparam int DISP_H = 240;
  localparam int ADDR_W = 17;
  localparam int EW     = ADDR_W + 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] data;
  logic dc, rxdone;
  logic pix_we, frame_start;
  logic [ADDR_W-1:0] pix_addr;
  logic [15:0] pix_data;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  spi_lcd_cmd_decoder #(.DISP_W(DISP_W), .DISP_H(DISP_H), .ADDR_W(ADDR_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_dc(dc), .i_rxdone(rxdone),
    .o_pix_we(pix_we), .o_pix_addr(pix_addr), .o_pix_data(pix_data),
    .o_frame_start(frame_start), .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  logic [ADDR_W-1:0] last_addr;
  logic [15:0]       last_data;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 drop data, 1 CASET, 2 RASET, 3 RAMWR, 4 MADCTL
  int m_xs, m_xe, m_ys, m_ye, m_mode, m_np, m_k, m_have_hi, m_hi, m_bgr;
  int m_p[4];

  task automatic model_reset();
    m_xs = 0; m_xe = DISP_W - 1; m_ys = 0; m_ye = DISP_H - 1;
    m_mode = 0; m_np = 0; m_k = 0; m_have_hi = 0; m_hi = 0; m_bgr = 0;
    exp_q.delete();
  endtask

  task automatic model_byte(input bit d_c, input logic [7:0] b, output bit e_we, output bit e_fs);
    int s, e, lim, w, h, x, y, pix;
    logic [15:0] p16, o16;
    e_we = 1'b0;
    e_fs = 1'b0;
    if (!d_c) begin
      m_np = 0;
      m_have_hi = 0;
      case (b)
        8'h2A: m_mode = 1;
        8'h2B: m_mode = 2;
        8'h2C: begin m_mode = 3; m_k = 0; e_fs = 1'b1; end
        8'h01: begin
          m_mode = 0; m_xs = 0; m_xe = DISP_W - 1; m_ys = 0; m_ye = DISP_H - 1; m_bgr = 0;
        end
`ifdef SPI_CMD_MADCTL_EN
        8'h36: m_mode = 4;
`endif
        default: m_mode = 0;
      endcase
    end else begin
      case (m_mode)
        1, 2: begin
          if (m_np < 4) begin
            m_p[m_np] = b;
            m_np++;
            if (m_np == 4) begin
              s = m_p[0] * 256 + m_p[1];
              e = m_p[2] * 256 + m_p[3];
              lim = (m_mode == 1) ? DISP_W : DISP_H;
              if (s <= e && e < lim) begin
                if (m_mode == 1) begin m_xs = s; m_xe = e; end
                else begin m_ys = s; m_ye = e; end
              end
            end
          end
        end
        3: begin
          if (!m_have_hi) begin
            m_hi = b;
            m_have_hi = 1;
          end else begin
            m_have_hi = 0;
            pix = m_hi * 256 + b;
            p16 = 16'(pix);
            o16 = m_bgr ? {p16[4:0], p16[10:5], p16[15:11]} : p16;
            w = m_xe - m_xs + 1;
            h = m_ye - m_ys + 1;
            x = m_xs + (m_k % w);
            y = m_ys + ((m_k / w) % h);
            m_k = (m_k + 1) % (w * h);
            exp_q.push_back({ADDR_W'(y * DISP_W + x), o16});
            e_we = 1'b1;
          end
        end
        4: begin
          if (m_np == 0) begin m_bgr = b[3]; m_np = 1; end
        end
        default: ;
      endcase
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input bit d_c, input logic [7:0] b);
    bit e_we, e_fs;
    logic [EW-1:0] e;
    @(negedge clk);
    dc = d_c; data = b; rxdone = 1'b1;
    model_byte(d_c, b, e_we, e_fs);
    @(negedge clk);
    rxdone = 1'b0; data = 8'($urandom); dc = 1'($urandom);
    check_val("we", pix_we, e_we);
    check_val("frame_start", frame_start, e_fs);
    if (pix_we) begin last_addr = pix_addr; last_data = pix_data; end
    if (e_we) begin
      e = exp_q.pop_front();
      check_val("addr", pix_addr, e[EW-1:16]);
      check_val("data", pix_data, e[15:0]);
    end
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      check_val("we_idle", pix_we, 0);
      check_val("fs_idle", frame_start, 0);
    end
  endtask

  task automatic cmd(input logic [7:0] b);
    send(1'b0, b);
  endtask

  task automatic pixel(input logic [15:0] p);
    send(1'b1, p[15:8]);
    send(1'b1, p[7:0]);
  endtask

  // n bytes: start hi/lo, end hi/lo, then random surplus bytes
  task automatic params(input int n, input int s, input int e);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      case (i)
        0: b = 8'(s >> 8);
        1: b = 8'(s);
        2: b = 8'(e >> 8);
        3: b = 8'(e);
        default: b = 8'($urandom);
      endcase
      send(1'b1, b);
    end
  endtask

  // ---------------- stimulus ----------------
  int exp_tab[5];
  int s, e, n, r;

  initial begin
    rst_n = 1'b0; rxdone = 1'b0; dc = 1'b0; data = 8'h00;
    last_addr = '0; last_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_val("rst_we", pix_we, 0);
    check_val("rst_addr", pix_addr, 0);
    check_val("rst_data", pix_data, 0);
    check_val("rst_fs", frame_start, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_we", pix_we, 0);

    // First pixel after reset lands at the origin.
    cmd(8'h2C);
    pixel(16'hF800);
    check_val("first_addr", last_addr, 0);
    check_val("first_data", last_data, 16'hF800);

    // 2x2 window at (10..11, 5..6) and wrap back to the start.
    exp_tab = '{1610, 1611, 1930, 1931, 1610};
    cmd(8'h2A); params(4, 10, 11);
    cmd(8'h2B); params(4, 5, 6);
    cmd(8'h2C);
    for (int i = 0; i < 5; i++) begin
      pixel(16'($urandom));
      check_val("win_addr", last_addr, exp_tab[i]);
    end

    // start > end is rejected.
    cmd(8'h01);
    cmd(8'h2A); params(4, 16, 5);
    cmd(8'h2C); pixel(16'h0BAD);
    check_val("bad_caset_addr", last_addr, 0);

    // Orphan high byte discarded, RAMWR restarts.
    cmd(8'h2C); send(1'b1, 8'hAB);
    cmd(8'h2C); pixel(16'h1234);
    check_val("orphan_addr", last_addr, 0);
    check_val("orphan_data", last_data, 16'h1234);

    // Bottom-right corner and its wrap.
    cmd(8'h2A); params(4, 318, 319);
    cmd(8'h2B); params(4, 238, 239);
    cmd(8'h2C);
    exp_tab = '{76478, 76479, 76798, 76799, 76478};
    for (int i = 0; i < 5; i++) begin
      pixel(16'($urandom));
      check_val("corner_addr", last_addr, exp_tab[i]);
    end
    // end == DISP_W / DISP_H rejected, window stays at the corner.
    cmd(8'h2A); params(4, 0, 320);
    cmd(8'h2B); params(4, 0, 240);
    cmd(8'h2C); pixel(16'h5555);
    check_val("edge_reject_addr", last_addr, 76478);

    // Truncated parameter list leaves window unchanged; surplus bytes dropped.
    cmd(8'h01);
    cmd(8'h2A); params(3, 5, 9);
    cmd(8'h2B); params(7, 1, 1);
    cmd(8'h2C); pixel(16'h7777);
    check_val("trunc_addr", last_addr, 320);

    // MADCTL BGR swap.
    cmd(8'h01);
    cmd(8'h36); send(1'b1, 8'h08);
    cmd(8'h2C); pixel(16'hF800);
`ifdef SPI_CMD_MADCTL_EN
    check_val("madctl_data", last_data, 16'h001F);
`else
    check_val("madctl_data", last_data, 16'hF800);
`endif
    cmd(8'h01);

    // Asynchronous reset in the middle of a pixel.
    cmd(8'h2A); params(4, 3, 4);
    cmd(8'h2C); pixel(16'h4321);
    send(1'b1, 8'hAA);
    @(negedge clk);
    dc = 1'b1; data = 8'hCD; rxdone = 1'b1; rst_n = 1'b0;
    #1;
    check_val("async_rst_addr", pix_addr, 0);
    check_val("async_rst_data", pix_data, 0);
    @(negedge clk);
    check_val("async_rst_we", pix_we, 0);
    rxdone = 1'b0;
    rst_n = 1'b1;
    model_reset();
    pixel(16'hFFFF);  // no RAMWR since reset: dropped

    // Random traffic.
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 9);
      n = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 6) : 4;
      case (r)
        0, 1: begin
          s = $urandom_range(0, DISP_W - 1);
          e = s + $urandom_range(0, 4) - (($urandom_range(0, 5) == 0) ? 2 : 0);
          cmd(8'h2A); params(n, s, e);
        end
        2, 3: begin
          s = $urandom_range(0, DISP_H - 1);
          e = s + $urandom_range(0, 4) - (($urandom_range(0, 5) == 0) ? 2 : 0);
          cmd(8'h2B); params(n, s, e);
        end
        4, 5, 6, 7: begin
          cmd(8'h2C);
          repeat ($urandom_range(0, 14)) send(1'b1, 8'($urandom));
        end
        8: begin
          if ($urandom_range(0, 1)) cmd(8'h01);
          else begin cmd(8'h36); repeat ($urandom_range(0, 2)) send(1'b1, 8'($urandom)); end
        end
        default: begin
          cmd(8'($urandom));
          repeat ($urandom_range(0, 3)) send(1'b1, 8'($urandom));
        end
      endcase
    end

    check_val("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
